// File: rtl/rob_pkg.sv
// Shared defaults and types for the tag-based reorder buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rob_pkg;

  localparam int ROB_DEPTH = 4;
  localparam int ROB_WIDTH = 8;
  localparam int ROB_ID_W  = $clog2(ROB_DEPTH);

  // ID handed to the requester, and the wrap-aware pointer.
  // The pointer carries one extra bit so that full and empty can be told apart.
  typedef logic [ROB_ID_W-1:0] rob_id_t;
  typedef logic [ROB_ID_W:0]   rob_ptr_t;

endpackage

// File: rtl/double_buffer.sv
// Two-entry valid/ready register stage with fully registered outputs.
// Latency: 1 cycle from an up handshake to down_valid.
// Backpressure: up_ready drops only when both entries are held, so a one-per-cycle stream is sustained.
//
// Ports:
//   clk, rst                          clock, async active-high reset
//   up_valid/up_ready/up_data         upstream side
//   down_valid/down_ready/down_data   downstream side, driven from registers
module double_buffer #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [width-1:0] up_data,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [width-1:0] down_data
);

  logic [width-1:0] slot_q [2];
  logic             wr_sel;
  logic             rd_sel;
  logic [1:0]       cnt;
  logic             push;
  logic             pop;

  assign up_ready   = (cnt != 2'd2);
  assign down_valid = (cnt != 2'd0);
  assign down_data  = slot_q[rd_sel];
  assign push       = up_valid & up_ready;
  assign pop        = down_valid & down_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) wr_sel <= ~wr_sel;
      if (pop)  rd_sel <= ~rd_sel;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      slot_q[wr_sel] <= up_data;
    end
  end

endmodule

// File: rtl/rob_storage.sv
// Slot storage for the reorder buffer: payload array plus per-slot allocated/filled bits.
// Latency: writes land on the next clk edge; the read port is combinational.
// Backpressure: none; the owner decides when each port fires.
//
// Ports:
//   clk, rst                        clock, async active-high reset (clears the bits, not mem)
//   alloc_en/alloc_idx              mark a slot allocated and not yet filled
//   fill_en/fill_idx/fill_data      store a payload and mark the slot filled
//   clear_en/clear_idx              release a slot
//   rd_idx -> rd_data               combinational read of one payload
//   alloc_bits, done_bits           per-slot status, registered
module rob_storage
  import rob_pkg::*;
#(
  parameter  int width    = ROB_WIDTH,
  parameter  int depth    = ROB_DEPTH,
  localparam int id_width = $clog2(depth)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc_en,
  input  logic [id_width-1:0] alloc_idx,
  input  logic                fill_en,
  input  logic [id_width-1:0] fill_idx,
  input  logic [width-1:0]    fill_data,
  input  logic                clear_en,
  input  logic [id_width-1:0] clear_idx,
  input  logic [id_width-1:0] rd_idx,
  output logic [depth-1:0]    alloc_bits,
  output logic [depth-1:0]    done_bits,
  output logic [width-1:0]    rd_data
);

  logic [width-1:0] mem [depth];

  // The owner guarantees that the three ports never target the same slot
  // in one cycle, so the update order below does not matter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alloc_bits <= '0;
      done_bits  <= '0;
    end else begin
      if (clear_en) begin
        alloc_bits[clear_idx] <= 1'b0;
        done_bits[clear_idx]  <= 1'b0;
      end
      if (alloc_en) begin
        alloc_bits[alloc_idx] <= 1'b1;
        done_bits[alloc_idx]  <= 1'b0;
      end
      if (fill_en) begin
        done_bits[fill_idx] <= 1'b1;
      end
    end
  end

  // The payload array is not reset; a slot is only read once its done bit is set.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      mem[fill_idx] <= fill_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/reorder_buffer_ooo.sv
// Tag-based reorder buffer: grants IDs in order, accepts tagged responses in any order, and streams data out in ID order.
// Latency: a response to the head slot shows on down_valid 1 cycle later (2 cycles with ROB_OUT_SKID_EN).
// Backpressure: alloc_ready is low while all IDs are outstanding; the head is held while down_ready is low; responses are never stalled.
//
// Ports:
//   clk, rst                             clock, async active-high reset
//   alloc_valid/alloc_ready/alloc_id     ID request handshake; alloc_id is the ID granted
//   resp_valid/resp_id/resp_data         tagged response, always accepted
//   resp_err                             one-cycle pulse for a response to a free or already-filled ID
//   down_valid/down_ready/down_data      in-order output stream
// Build option: define ROB_OUT_SKID_EN to register the output stream through a double_buffer.
module reorder_buffer_ooo
  import rob_pkg::*;
#(
  parameter  int width    = ROB_WIDTH,
  parameter  int depth    = ROB_DEPTH,
  localparam int id_width = $clog2(depth)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc_valid,
  output logic                alloc_ready,
  output logic [id_width-1:0] alloc_id,
  input  logic                resp_valid,
  input  logic [id_width-1:0] resp_id,
  input  logic [width-1:0]    resp_data,
  output logic                resp_err,
  output logic                down_valid,
  input  logic                down_ready,
  output logic [width-1:0]    down_data
);

  localparam logic [id_width:0] full_count = (id_width+1)'(depth);

  logic [id_width:0]   wr_ptr;
  logic [id_width:0]   rd_ptr;
  logic [id_width:0]   count;
  logic [id_width-1:0] wr_idx;
  logic [id_width-1:0] rd_idx;
  logic [depth-1:0]    alloc_bits;
  logic [depth-1:0]    done_bits;
  logic [width-1:0]    head_data;
  logic                head_valid;
  logic                head_take;
  logic                alloc_fire;
  logic                resp_ok;
  logic                pop;

  assign wr_idx = wr_ptr[id_width-1:0];
  assign rd_idx = rd_ptr[id_width-1:0];
  assign count  = wr_ptr - rd_ptr;

  // Only registered state feeds alloc_ready, so a pop does not open a slot
  // until the following cycle.
  assign alloc_ready = (count != full_count);
  assign alloc_id    = wr_idx;
  assign alloc_fire  = alloc_valid & alloc_ready;

  // Checked against the registered bits: a response to the ID being granted
  // in this same cycle still sees the slot free and is rejected.
  assign resp_ok = alloc_bits[resp_id] & ~done_bits[resp_id];

  assign head_valid = alloc_bits[rd_idx] & done_bits[rd_idx];
  assign pop        = head_valid & head_take;

  rob_storage #(
    .width (width),
    .depth (depth)
  ) u_storage (
    .clk        (clk),
    .rst        (rst),
    .alloc_en   (alloc_fire),
    .alloc_idx  (wr_idx),
    .fill_en    (resp_valid & resp_ok),
    .fill_idx   (resp_id),
    .fill_data  (resp_data),
    .clear_en   (pop),
    .clear_idx  (rd_idx),
    .rd_idx     (rd_idx),
    .alloc_bits (alloc_bits),
    .done_bits  (done_bits),
    .rd_data    (head_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      resp_err <= 1'b0;
    end else begin
      if (alloc_fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop)        rd_ptr <= rd_ptr + 1'b1;
      resp_err <= resp_valid & ~resp_ok;
    end
  end

`ifdef ROB_OUT_SKID_EN
  double_buffer #(
    .width (width)
  ) u_out_stage (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (head_valid),
    .up_ready   (head_take),
    .up_data    (head_data),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_data  (down_data)
  );
`else
  // The head slot is read straight out; it stays put until it is popped,
  // which keeps down_valid and down_data stable under backpressure.
  assign head_take  = down_ready;
  assign down_valid = head_valid;
  assign down_data  = head_data;
`endif

endmodule
